id_ex_stage: RTL and testbench

- ID/EX pipeline register sitting directly downstream of the instruction decoder.
- Latches the decoder's control bundle, register operands, immediate and register specifiers into the EX stage each cycle.
- Contains load-use hazard detection: inserts a bubble into EX and signals IF/ID to hold.
- Supports flush (branch/jump redirect), global hold (downstream stall) and a saturating load-use stall counter.

---
 rtl/mips_pkg.sv | 55 +++++
 rtl/hazard_detect.sv | 34 +++
 rtl/id_ex_stage.sv | 147 ++++++++++++++
 tb/tb_id_ex_stage.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared encodings, control bundle type and helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam logic [1:0] c_mem_none    = 2'b00;
    localparam logic [1:0] c_mem_word    = 2'b01;
    localparam logic [1:0] c_mem_byte    = 2'b10;
    localparam logic [1:0] c_mem_half    = 2'b11;

    localparam logic [1:0] c_jump_none   = 2'b00;
    localparam logic [1:0] c_jump_j      = 2'b01;
    localparam logic [1:0] c_jump_jal    = 2'b10;
    localparam logic [1:0] c_jump_jr     = 2'b11;

    localparam logic [1:0] c_aluop_rtype = 2'b00;
    localparam logic [1:0] c_aluop_imm   = 2'b01;

    localparam logic [5:0] c_op_rtype    = 6'h00;
    localparam logic [5:0] c_op_j        = 6'h02;
    localparam logic [5:0] c_op_jal      = 6'h03;
    localparam logic [5:0] c_op_beq      = 6'h04;
    localparam logic [5:0] c_op_bne      = 6'h05;
    localparam logic [5:0] c_op_addi     = 6'h08;
    localparam logic [5:0] c_op_lb       = 6'h20;
    localparam logic [5:0] c_op_lh       = 6'h21;
    localparam logic [5:0] c_op_lw       = 6'h23;
    localparam logic [5:0] c_op_sb       = 6'h28;
    localparam logic [5:0] c_op_sh       = 6'h29;
    localparam logic [5:0] c_op_sw       = 6'h2b;

    localparam logic [4:0] c_reg_zero    = 5'd0;

    typedef struct packed {
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] jump;
        logic [1:0] branch;
        logic [1:0] mem_read;
        logic [1:0] mem_write;
        logic [1:0] alu_op;
    } ctrl_t;

    // rt is a source operand unless the immediate replaces it; stores always read it.
    function automatic logic uses_rt(input logic alu_src, input logic [1:0] mem_write);
        return ~alu_src | (mem_write != c_mem_none);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_detect
//  Description : Combinational load-use comparator between EX and ID.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import mips_pkg::*;
(
    input  logic       i_ex_valid,
    input  logic [1:0] i_ex_mem_read,
    input  logic [4:0] i_ex_rt,
    input  logic       i_id_valid,
    input  logic       i_flush,
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_id_alu_src,
    input  logic [1:0] i_id_mem_write,
    output logic       o_load_use_stall
);

    logic w_ex_is_load;
    logic w_rs_hit;
    logic w_rt_hit;

    // A load targeting $0 produces nothing worth waiting for.
    assign w_ex_is_load = i_ex_valid & (i_ex_mem_read != c_mem_none) & (i_ex_rt != c_reg_zero);
    assign w_rs_hit     = (i_ex_rt == i_id_rs);
    assign w_rt_hit     = uses_rt(i_id_alu_src, i_id_mem_write) & (i_ex_rt == i_id_rt);

    assign o_load_use_stall = w_ex_is_load & i_id_valid & ~i_flush & (w_rs_hit | w_rt_hit);

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register with flush, hold and load-use bubble.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [5:0]        id_funct,
    input  logic              id_reg_dst,
    input  logic              id_mem_to_reg,
    input  logic              id_alu_src,
    input  logic              id_reg_write,
    input  logic [1:0]        id_jump,
    input  logic [1:0]        id_branch,
    input  logic [1:0]        id_mem_read,
    input  logic [1:0]        id_mem_write,
    input  logic [1:0]        id_alu_op,
    input  logic              flush,
    input  logic              hold,
    output logic              load_use_stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [5:0]        ex_funct,
    output logic              ex_reg_dst,
    output logic              ex_mem_to_reg,
    output logic              ex_alu_src,
    output logic              ex_reg_write,
    output logic [1:0]        ex_jump,
    output logic [1:0]        ex_branch,
    output logic [1:0]        ex_mem_read,
    output logic [1:0]        ex_mem_write,
    output logic [1:0]        ex_alu_op,
    output logic [CNT_W-1:0]  stall_cnt
);

    ctrl_t             w_id_ctrl;
    ctrl_t             r_ctrl;
    logic              w_load_use_stall;
    logic              r_valid;
    logic [DATA_W-1:0] r_pc4;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    logic [4:0]        r_rs;
    logic [4:0]        r_rt;
    logic [4:0]        r_rd;
    logic [5:0]        r_funct;
    logic [CNT_W-1:0]  r_stall_cnt;

    // An empty ID slot must not leak decoder garbage into EX controls.
    assign w_id_ctrl = id_valid ? '{id_reg_dst, id_mem_to_reg, id_alu_src, id_reg_write,
                                    id_jump, id_branch, id_mem_read, id_mem_write, id_alu_op}
                                : '0;

    hazard_detect u_hazard_detect (
        .i_ex_valid       (r_valid),
        .i_ex_mem_read    (r_ctrl.mem_read),
        .i_ex_rt          (r_rt),
        .i_id_valid       (id_valid),
        .i_flush          (flush),
        .i_id_rs          (id_rs),
        .i_id_rt          (id_rt),
        .i_id_alu_src     (id_alu_src),
        .i_id_mem_write   (id_mem_write),
        .o_load_use_stall (w_load_use_stall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_ctrl      <= '0;
            r_pc4       <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rd        <= '0;
            r_funct     <= '0;
            r_stall_cnt <= '0;
        end else if (!hold) begin
            if (flush || w_load_use_stall) begin
                // Bubble: payload is left stale, consumers qualify on ex_valid.
                r_valid <= 1'b0;
                r_ctrl  <= '0;
                if (w_load_use_stall && (r_stall_cnt != '1)) begin
                    r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                end
            end else begin
                r_valid   <= id_valid;
                r_ctrl    <= w_id_ctrl;
                r_pc4     <= id_pc4;
                r_rs_data <= id_rs_data;
                r_rt_data <= id_rt_data;
                r_imm     <= id_imm;
                r_rs      <= id_rs;
                r_rt      <= id_rt;
                r_rd      <= id_rd;
                r_funct   <= id_funct;
            end
        end
    end

    assign load_use_stall = w_load_use_stall;
    assign ex_valid       = r_valid;
    assign ex_pc4         = r_pc4;
    assign ex_rs_data     = r_rs_data;
    assign ex_rt_data     = r_rt_data;
    assign ex_imm         = r_imm;
    assign ex_rs          = r_rs;
    assign ex_rt          = r_rt;
    assign ex_rd          = r_rd;
    assign ex_funct       = r_funct;
    assign ex_reg_dst     = r_ctrl.reg_dst;
    assign ex_mem_to_reg  = r_ctrl.mem_to_reg;
    assign ex_alu_src     = r_ctrl.alu_src;
    assign ex_reg_write   = r_ctrl.reg_write;
    assign ex_jump        = r_ctrl.jump;
    assign ex_branch      = r_ctrl.branch;
    assign ex_mem_read    = r_ctrl.mem_read;
    assign ex_mem_write   = r_ctrl.mem_write;
    assign ex_alu_op      = r_ctrl.alu_op;
    assign stall_cnt      = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_stage
//  Description : Scoreboard bench for id_ex_stage (plus a narrow-counter copy).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;
    import mips_pkg::*;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;
    localparam int SAT_W  = 4;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc4;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic        reg_dst;
        logic        mem_to_reg;
        logic        alu_src;
        logic        reg_write;
        logic [1:0]  jump;
        logic [1:0]  branch;
        logic [1:0]  mem_read;
        logic [1:0]  mem_write;
        logic [1:0]  alu_op;
    } id_t;

    typedef struct packed {
        id_t              ex;
        logic [CNT_W-1:0] cnt;
    } ex_t;

    typedef struct packed {
        logic lus;
        ex_t  st;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic hold;
    id_t  idb;

    logic              load_use_stall, ex_valid;
    logic [DATA_W-1:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]        ex_rs, ex_rt, ex_rd;
    logic [5:0]        ex_funct;
    logic              ex_reg_dst, ex_mem_to_reg, ex_alu_src, ex_reg_write;
    logic [1:0]        ex_jump, ex_branch, ex_mem_read, ex_mem_write, ex_alu_op;
    logic [CNT_W-1:0]  stall_cnt;

    logic              s_load_use_stall, s_ex_valid;
    logic [DATA_W-1:0] s_ex_pc4, s_ex_rs_data, s_ex_rt_data, s_ex_imm;
    logic [4:0]        s_ex_rs, s_ex_rt, s_ex_rd;
    logic [5:0]        s_ex_funct;
    logic              s_ex_reg_dst, s_ex_mem_to_reg, s_ex_alu_src, s_ex_reg_write;
    logic [1:0]        s_ex_jump, s_ex_branch, s_ex_mem_read, s_ex_mem_write, s_ex_alu_op;
    logic [SAT_W-1:0]  s_stall_cnt;

    ex_t              m;
    logic [SAT_W-1:0] m_sat;
    exp_t             sb[$];
    logic             obs_lus;
    int               n_tests = 0;
    int               n_fail  = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(idb.valid), .id_pc4(idb.pc4),
        .id_rs_data(idb.rs_data), .id_rt_data(idb.rt_data), .id_imm(idb.imm),
        .id_rs(idb.rs), .id_rt(idb.rt), .id_rd(idb.rd), .id_funct(idb.funct),
        .id_reg_dst(idb.reg_dst), .id_mem_to_reg(idb.mem_to_reg), .id_alu_src(idb.alu_src),
        .id_reg_write(idb.reg_write), .id_jump(idb.jump), .id_branch(idb.branch),
        .id_mem_read(idb.mem_read), .id_mem_write(idb.mem_write), .id_alu_op(idb.alu_op),
        .flush(flush), .hold(hold), .load_use_stall(load_use_stall), .ex_valid(ex_valid),
        .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_funct(ex_funct),
        .ex_reg_dst(ex_reg_dst), .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src),
        .ex_reg_write(ex_reg_write), .ex_jump(ex_jump), .ex_branch(ex_branch),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_alu_op(ex_alu_op),
        .stall_cnt(stall_cnt)
    );

    id_ex_stage #(.DATA_W(DATA_W), .CNT_W(SAT_W)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(idb.valid), .id_pc4(idb.pc4),
        .id_rs_data(idb.rs_data), .id_rt_data(idb.rt_data), .id_imm(idb.imm),
        .id_rs(idb.rs), .id_rt(idb.rt), .id_rd(idb.rd), .id_funct(idb.funct),
        .id_reg_dst(idb.reg_dst), .id_mem_to_reg(idb.mem_to_reg), .id_alu_src(idb.alu_src),
        .id_reg_write(idb.reg_write), .id_jump(idb.jump), .id_branch(idb.branch),
        .id_mem_read(idb.mem_read), .id_mem_write(idb.mem_write), .id_alu_op(idb.alu_op),
        .flush(flush), .hold(hold), .load_use_stall(s_load_use_stall), .ex_valid(s_ex_valid),
        .ex_pc4(s_ex_pc4), .ex_rs_data(s_ex_rs_data), .ex_rt_data(s_ex_rt_data), .ex_imm(s_ex_imm),
        .ex_rs(s_ex_rs), .ex_rt(s_ex_rt), .ex_rd(s_ex_rd), .ex_funct(s_ex_funct),
        .ex_reg_dst(s_ex_reg_dst), .ex_mem_to_reg(s_ex_mem_to_reg), .ex_alu_src(s_ex_alu_src),
        .ex_reg_write(s_ex_reg_write), .ex_jump(s_ex_jump), .ex_branch(s_ex_branch),
        .ex_mem_read(s_ex_mem_read), .ex_mem_write(s_ex_mem_write), .ex_alu_op(s_ex_alu_op),
        .stall_cnt(s_stall_cnt)
    );

    function automatic ex_t dut_state();
        return {ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd, ex_funct,
                ex_reg_dst, ex_mem_to_reg, ex_alu_src, ex_reg_write, ex_jump, ex_branch,
                ex_mem_read, ex_mem_write, ex_alu_op, stall_cnt};
    endfunction

    // ---------------- instruction builders ----------------
    function automatic id_t ins_base();
        id_t d;
        d         = '0;
        d.valid   = 1'b1;
        d.pc4     = $urandom;
        d.rs_data = $urandom;
        d.rt_data = $urandom;
        d.imm     = $urandom;
        d.rd      = 5'($urandom);
        d.funct   = 6'($urandom);
        return d;
    endfunction

    function automatic id_t mk_lw(input logic [4:0] rs, input logic [4:0] rt);
        id_t d = ins_base();
        d.rs = rs; d.rt = rt; d.alu_src = 1'b1; d.mem_to_reg = 1'b1; d.reg_write = 1'b1;
        d.mem_read = c_mem_word; d.alu_op = c_aluop_imm;
        return d;
    endfunction

    function automatic id_t mk_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        id_t d = ins_base();
        d.rs = rs; d.rt = rt; d.rd = rd; d.reg_dst = 1'b1; d.reg_write = 1'b1;
        d.alu_op = c_aluop_rtype; d.funct = 6'h20;
        return d;
    endfunction

    function automatic id_t mk_addi(input logic [4:0] rs, input logic [4:0] rt);
        id_t d = ins_base();
        d.rs = rs; d.rt = rt; d.alu_src = 1'b1; d.reg_write = 1'b1; d.alu_op = c_aluop_imm;
        return d;
    endfunction

    function automatic id_t mk_sw(input logic [4:0] rs, input logic [4:0] rt);
        id_t d = ins_base();
        d.rs = rs; d.rt = rt; d.alu_src = 1'b1; d.mem_write = c_mem_word; d.alu_op = c_aluop_imm;
        return d;
    endfunction

    function automatic id_t mk_jal();
        id_t d = ins_base();
        d.rd = 5'd31; d.jump = c_jump_jal; d.reg_write = 1'b1;
        return d;
    endfunction

    // Empty slot carrying random control garbage, which must be dropped.
    function automatic id_t mk_nop();
        id_t d = ins_base();
        d[13:0] = 14'($urandom);
        d.valid = 1'b0;
        return d;
    endfunction

    // ---------------- reference model ----------------
    function automatic logic model_lus(input ex_t e, input id_t d, input logic fl);
        logic rt_used;
        rt_used = !d.alu_src || (d.mem_write != 2'b00);
        return e.ex.valid && (e.ex.mem_read != 2'b00) && (e.ex.rt != 5'd0) && d.valid && !fl &&
               ((e.ex.rt == d.rs) || (rt_used && (e.ex.rt == d.rt)));
    endfunction

    function automatic ex_t model_next(input ex_t e, input id_t d, input logic fl, input logic hd);
        ex_t  n;
        logic l;
        n = e;
        l = model_lus(e, d, fl);
        if (hd) return n;
        if (fl || l) begin
            n.ex.valid   = 1'b0;
            n.ex[13:0]   = '0;
            if (l && (n.cnt != {CNT_W{1'b1}})) n.cnt = n.cnt + 1'b1;
        end else begin
            n.ex = d;
            if (!d.valid) n.ex[13:0] = '0;
        end
        return n;
    endfunction

    // Drive one clock with the current inputs; the expectation is queued first.
    task automatic cycle();
        exp_t e;
        #1;
        obs_lus = load_use_stall;
        e.lus   = model_lus(m, idb, flush);
        if (!hold && e.lus && (m_sat != {SAT_W{1'b1}})) m_sat = m_sat + 1'b1;
        m    = model_next(m, idb, flush, hold);
        e.st = m;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] rreg();
        return 5'($urandom_range(0, 3));
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0; flush = 1'b0; hold = 1'b0; idb = mk_nop();
        m = '0; m_sat = '0;
        #12;
        n_tests++;
        if (dut_state() !== ex_t'(0) || load_use_stall !== 1'b0 || s_stall_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_initial: got st=%h lus=%b sat=%h, want all zero", dut_state(), load_use_stall, s_stall_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        e = sb.pop_front(); n_tests++;
        if (obs_lus !== e.lus || dut_state() !== e.st) begin
            n_fail++;
            $display("FAIL reset_release: got lus=%b st=%h, want lus=%b st=%h", obs_lus, dut_state(), e.lus, e.st);
        end
        idb = mk_lw(5'd1, 5'd8);
        cycle();
        e = sb.pop_front(); n_tests++;
        if (obs_lus !== e.lus || dut_state() !== e.st) begin
            n_fail++;
            $display("FAIL reset_prep: got lus=%b st=%h, want lus=%b st=%h", obs_lus, dut_state(), e.lus, e.st);
        end
        idb = mk_add(5'd8, 5'd2, 5'd3);
        #2;
        rst_n = 1'b0;
        #1;
        m = '0; m_sat = '0;
        n_tests++;
        if (dut_state() !== ex_t'(0) || load_use_stall !== 1'b0 || s_stall_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got st=%h lus=%b sat=%h, want all zero", dut_state(), load_use_stall, s_stall_cnt);
        end
        idb = mk_nop();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        e = sb.pop_front(); n_tests++;
        if (obs_lus !== e.lus || dut_state() !== e.st) begin
            n_fail++;
            $display("FAIL reset_resume: got lus=%b st=%h, want lus=%b st=%h", obs_lus, dut_state(), e.lus, e.st);
        end
    endtask

    task automatic test_dependent_load();
        exp_t e;
        idb = mk_lw(5'd1, 5'd8);
        cycle();
        e = sb.pop_front(); n_tests++;
        if (obs_lus !== e.lus || dut_state() !== e.st) begin
            n_fail++;
            $display("FAIL dep_lw: got lus=%b st=%h, want lus=%b st=%h", obs_lus, dut_state(), e.lus, e.st);
        end
        idb = mk_add(5'd8, 5'd2, 5'd3);
        cycle();
        e = sb.pop_front(); n_tests++;
        if (obs_lus !== e.lus || dut_state() !== e.st) begin
            n_fail++;
            $display("FAIL dep_bubble: got lus=%b st=%h, want lus=%b st=%h", obs_lus, dut_state(), e.lus, e.st);
        end
        n_tests++;
        if (obs_lus !== 1'b1 || ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin
            n_fail++;
            $display("FAIL dep_stall: got lus=%b valid=%b reg_write=%b, want 1 0 0", obs_lus, ex_valid, ex_reg_write);
        end
        cycle();
        e = sb.pop_front(); n_tests++;
        if (obs_lus !== e.lus || dut_state() !== e.st) begin
            n_fail++;
            $display("FAIL dep_capture: got lus=%b st=%h, want lus=%b st=%h", obs_lus, dut_state(), e.lus, e.st);
        end
        n_tests++;
        if (obs_lus !== 1'b0 || ex_valid !== 1'b1 || ex_reg_write !== 1'b1 || ex_rs !== 5'd8 || stall_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL dep_after: got lus=%b valid=%b rw=%b rs=%0d cnt=%0d, want 0 1 1 8 1",
                     obs_lus, ex_valid, ex_reg_write, ex_rs, stall_cnt);
        end
    endtask

    task automatic test_rt_usage();
        exp_t       e;
        id_t        second [4];
        logic       want   [4];
        logic [4:0] first_rt;
        second[0] = mk_addi(5'd2, 5'd8);     want[0] = 1'b0;
        second[1] = mk_sw(5'd3, 5'd8);       want[1] = 1'b1;
        second[2] = mk_add(5'd0, 5'd0, 5'd4); want[2] = 1'b0;
        second[3] = mk_add(5'd4, 5'd8, 5'd5); want[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            first_rt = (i == 2) ? 5'd0 : 5'd8;
            idb = mk_lw(5'd1, first_rt);
            cycle();
            idb = second[i];
            cycle();
            n_tests++;
            if (obs_lus !== want[i]) begin
                n_fail++;
                $display("FAIL rt_usage[%0d]: got lus=%b, want %b", i, obs_lus, want[i]);
            end
            if (want[i]) cycle();
            idb = mk_nop();
            cycle();
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_tests++;
                if (dut_state() !== e.st && sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL rt_usage_state[%0d]: got st=%h, want st=%h", i, dut_state(), e.st);
                end
            end
        end
    endtask

    task automatic test_flush();
        exp_t             e;
        logic [CNT_W-1:0] c0;
        idb = mk_jal(); flush = 1'b1;
        cycle();
        e = sb.pop_front(); n_tests++;
        if (obs_lus !== e.lus || dut_state() !== e.st || ex_valid !== 1'b0 || ex_jump !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_jal: got lus=%b st=%h, want lus=%b st=%h", obs_lus, dut_state(), e.lus, e.st);
        end
        flush = 1'b0; idb = mk_lw(5'd1, 5'd9);
        cycle();
        e = sb.pop_front(); n_tests++;
        if (obs_lus !== e.lus || dut_state() !== e.st) begin
            n_fail++;
            $display("FAIL flush_lw: got lus=%b st=%h, want lus=%b st=%h", obs_lus, dut_state(), e.lus, e.st);
        end
        c0  = m.cnt;
        idb = mk_add(5'd9, 5'd9, 5'd4); flush = 1'b1;
        cycle();
        e = sb.pop_front(); n_tests++;
        if (obs_lus !== 1'b0 || stall_cnt !== c0 || ex_valid !== 1'b0 || dut_state() !== e.st) begin
            n_fail++;
            $display("FAIL flush_vs_stall: got lus=%b cnt=%0d st=%h, want lus=0 cnt=%0d st=%h",
                     obs_lus, stall_cnt, dut_state(), c0, e.st);
        end
        flush = 1'b0;
    endtask

    task automatic test_hold();
        exp_t e;
        ex_t  snap;
        idb = mk_lw(5'd1, 5'd10);
        cycle();
        e = sb.pop_front(); n_tests++;
        if (dut_state() !== e.st) begin
            n_fail++;
            $display("FAIL hold_prep: got st=%h, want st=%h", dut_state(), e.st);
        end
        snap = m;
        idb  = mk_add(5'd10, 5'd2, 5'd5); hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            flush = (i != 0);
            cycle();
            e = sb.pop_front(); n_tests++;
            if (obs_lus !== e.lus || dut_state() !== e.st || dut_state() !== snap) begin
                n_fail++;
                $display("FAIL hold[%0d]: got lus=%b st=%h, want lus=%b st=%h", i, obs_lus, dut_state(), e.lus, snap);
            end
        end
        hold = 1'b0;
        cycle();
        e = sb.pop_front(); n_tests++;
        if (dut_state() !== e.st || ex_valid !== 1'b0 || stall_cnt !== snap.cnt) begin
            n_fail++;
            $display("FAIL hold_release: got st=%h, want st=%h", dut_state(), e.st);
        end
        flush = 1'b0;
    endtask

    task automatic test_saturation();
        exp_t             e;
        logic [CNT_W-1:0] c0;
        c0  = m.cnt;
        idb = mk_lw(5'd11, 5'd11);
        for (int i = 0; i < 2 * ((1 << SAT_W) + 2); i++) begin
            cycle();
            e = sb.pop_front(); n_tests++;
            if (obs_lus !== e.lus || dut_state() !== e.st) begin
                n_fail++;
                $display("FAIL sat_step[%0d]: got lus=%b st=%h, want lus=%b st=%h", i, obs_lus, dut_state(), e.lus, e.st);
            end
        end
        n_tests++;
        if (s_stall_cnt !== {SAT_W{1'b1}} || stall_cnt !== c0 + 16'd18) begin
            n_fail++;
            $display("FAIL sat_final: got narrow=%h wide=%0d, want narrow=%h wide=%0d",
                     s_stall_cnt, stall_cnt, {SAT_W{1'b1}}, c0 + 16'd18);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0:       idb = mk_lw(rreg(), rreg());
                1:       idb = mk_add(rreg(), rreg(), rreg());
                2:       idb = mk_addi(rreg(), rreg());
                3:       idb = mk_sw(rreg(), rreg());
                4:       idb = mk_jal();
                default: idb = mk_nop();
            endcase
            flush = ($urandom_range(0, 7) == 0);
            hold  = ($urandom_range(0, 7) == 0);
            cycle();
            e = sb.pop_front(); n_tests++;
            if (obs_lus !== e.lus || dut_state() !== e.st) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got lus=%b st=%h, want lus=%b st=%h", i, obs_lus, dut_state(), e.lus, e.st);
            end
        end
        flush = 1'b0; hold = 1'b0;
        n_tests++;
        if (s_stall_cnt !== m_sat) begin
            n_fail++;
            $display("FAIL b2b_narrow_cnt: got %h, want %h", s_stall_cnt, m_sat);
        end
    endtask

    initial begin
        test_reset();
        test_dependent_load();
        test_rt_usage();
        test_flush();
        test_hold();
        test_saturation();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
